// File: rtl/spi_slave_if_if.sv
// Word-side interface of the SPI slave.
//   tx_data/tx_valid/tx_ready : word offered to the slave for transmission
//   rx_data/rx_valid/rx_ready : word received from the master
//   rx_overrun, tx_underrun, frame_abort : one-cycle status pulses
// Modport slave is the SPI block side; modport master is the local-logic side.
interface spi_slave_if_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_overrun;
  logic             tx_underrun;
  logic             frame_abort;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave, all four cpol/cpha modes, MSB- or LSB-first.
// SPI pins are oversampled in the wb_clk_i domain (wb_clk_i >= 4x sclk).
// Ports:
//   wb_clk_i, wb_rst_i   : system clock, synchronous active-high reset
//   cpol, cpha, lsb_first: mode controls, taken only while idle
//   ss_n_i, sclk_i, mosi_i : asynchronous SPI inputs
//   miso_o, miso_oe      : serial output and its enable
//   bus                  : word-side TX/RX valid/ready interface and status pulses
module spi_slave_if #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] TX_IDLE = {WIDTH{1'b1}}
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         cpol,
  input  logic         cpha,
  input  logic         lsb_first,
  input  logic         ss_n_i,
  input  logic         sclk_i,
  input  logic         mosi_i,
  output logic         miso_o,
  output logic         miso_oe,
  spi_slave_if_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // [0] metastability flop, [1] synchronised value, [2] history for edge detect.
  // Left unreset so a reset with ss_n held low cannot fake a fresh ss_n fall.
  logic [2:0] ss_pipe, sclk_pipe, mosi_pipe;

  always_ff @(posedge wb_clk_i) begin
    ss_pipe   <= {ss_pipe[1:0], ss_n_i};
    sclk_pipe <= {sclk_pipe[1:0], sclk_i};
    mosi_pipe <= {mosi_pipe[1:0], mosi_i};
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic             rx_done_q, rx_done_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             fwd_q, fwd_d;   // a full word has completed in this frame
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  logic ss_fall, ss_rise, sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cpha_eff, lsb_eff, load, shift, tx_wr;
  logic [WIDTH-1:0] word_ld, rx_shifted;

  assign ss_fall     = ss_pipe[2] & ~ss_pipe[1];
  assign ss_rise     = ~ss_pipe[2] & ss_pipe[1];
  assign sclk_edge   = sclk_pipe[2] ^ sclk_pipe[1];
  assign lead_edge   = sclk_edge & (sclk_pipe[1] != cpol_q);
  assign trail_edge  = sclk_edge & (sclk_pipe[1] == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  // Mode inputs are live in idle and frozen for the rest of the frame.
  assign cpha_eff = (state_q == StIdle) ? cpha : cpha_q;
  assign lsb_eff  = (state_q == StIdle) ? lsb_first : lsb_q;

  assign word_ld    = hold_full_q ? hold_q : TX_IDLE;
  assign rx_shifted = lsb_q ? {mosi_pipe[2], rx_sr_q[WIDTH-1:1]}
                            : {rx_sr_q[WIDTH-2:0], mosi_pipe[2]};
  assign tx_wr      = bus.tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_word_d   = rx_word_q;
    rx_done_d   = 1'b0;
    miso_d      = miso_q;
    oe_d        = oe_q;
    fwd_d       = fwd_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cpol_d = cpol;
        cpha_d = cpha;
        lsb_d  = lsb_first;
        if (ss_fall) begin
          state_d   = StActive;
          oe_d      = 1'b1;
          bit_cnt_d = '0;
          fwd_d     = 1'b0;
          load      = ~cpha_eff;
        end
      end
      StActive: begin
        if (ss_rise) begin
          state_d   = StIdle;
          abort_d   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          oe_d      = 1'b0;
          miso_d    = 1'b0;
          fwd_d     = 1'b0;
        end else if (sample_edge) begin
          rx_sr_d = rx_shifted;
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            rx_word_d = rx_shifted;
            rx_done_d = 1'b1;
            fwd_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (shift_edge) begin
          // Word boundary: cpha=1 loads at every word start, cpha=0 only after
          // the first word (the first word was loaded at ss_n fall).
          if ((bit_cnt_q == '0) && (cpha_q || fwd_q)) begin
            load = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx_sr holds the bits still to be driven; miso gets the head bit.
    if (load) begin
      underrun_d = ~hold_full_q;
      miso_d     = lsb_eff ? word_ld[0] : word_ld[WIDTH-1];
      tx_sr_d    = lsb_eff ? (word_ld >> 1) : (word_ld << 1);
    end else if (shift) begin
      miso_d  = lsb_eff ? tx_sr_q[0] : tx_sr_q[WIDTH-1];
      tx_sr_d = lsb_eff ? (tx_sr_q >> 1) : (tx_sr_q << 1);
    end

    hold_full_d = (hold_full_q & ~load) | tx_wr;
    if (tx_wr) begin
      hold_d = bus.tx_data;
    end

    if (rx_done_q) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = rx_word_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_word_q   <= '0;
      rx_done_q   <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      fwd_q       <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_word_q   <= rx_word_d;
      rx_done_q   <= rx_done_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      fwd_q       <= fwd_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign miso_o          = miso_q;
  assign miso_oe         = oe_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = overrun_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_abort = abort_q;

endmodule
